// File: rtl/imem_arbiter.sv
// imem_arbiter: two-port (fetch, loader) arbiter in front of a single-port
// word-addressed instruction memory. One grant per cycle, combinational grant
// and memory strobes, one-cycle response through a three-state response FSM.
// Optional feature: define IMEM_ARB_RR_EN for round-robin tie breaking;
// without it the loader always wins a tie.
module imem_arbiter #(
  parameter int unsigned MEMORY_SIZE = 1024,
  parameter int unsigned AW          = $clog2(MEMORY_SIZE / 4)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          l_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    F_RESP = 2'd1,
    L_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   resp_err_q, resp_err_d;
  logic   resp_we_q, resp_we_d;

  logic   f_bad, l_bad;
  logic   tie_to_f;
  logic   resp_f, resp_l;

  // Misaligned or out-of-range byte addresses are answered with an error
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(MEMORY_SIZE));
  endfunction

  assign f_bad = addr_bad(f_addr);
  assign l_bad = addr_bad(l_addr);

`ifdef IMEM_ARB_RR_EN
  logic last_l_q, last_l_d;

  // Tie goes to fetch when the loader held the most recent grant
  assign tie_to_f = last_l_q;

  // Round-robin pointer follows every grant
  always_comb begin
    last_l_d = last_l_q;
    if (f_gnt) begin
      last_l_d = 1'b0;
    end else if (l_gnt) begin
      last_l_d = 1'b1;
    end
  end

  // Pointer register; reset value makes fetch win the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      last_l_q <= 1'b1;
    end else begin
      last_l_q <= last_l_d;
    end
  end
`else
  assign tie_to_f = 1'b0;
`endif

  // Arbitration, memory strobes and response next-state
  always_comb begin
    f_gnt      = 1'b0;
    l_gnt      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    state_d    = IDLE;
    resp_err_d = 1'b0;
    resp_we_d  = 1'b0;

    if (!reset) begin
      if (f_req && l_req) begin
        f_gnt = tie_to_f;
        l_gnt = !tie_to_f;
      end else begin
        f_gnt = f_req;
        l_gnt = l_req;
      end

      if (f_gnt) begin
        mem_en     = !f_bad;
        mem_addr   = f_addr[AW+1:2];
        state_d    = F_RESP;
        resp_err_d = f_bad;
      end else if (l_gnt) begin
        mem_en     = !l_bad;
        mem_we     = l_we && !l_bad;
        mem_addr   = l_addr[AW+1:2];
        mem_wdata  = (l_we && !l_bad) ? l_wdata : 32'h0;
        state_d    = L_RESP;
        resp_err_d = l_bad;
        resp_we_d  = l_we && !l_bad;
      end
    end
  end

  // Response state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      resp_err_q <= 1'b0;
      resp_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_err_q <= resp_err_d;
      resp_we_q  <= resp_we_d;
    end
  end

  // Response outputs; a pending response is suppressed while reset is high
  always_comb begin
    resp_f   = (state_q == F_RESP) && !reset;
    resp_l   = (state_q == L_RESP) && !reset;

    f_rvalid = resp_f;
    f_err    = resp_f && resp_err_q;
    f_rdata  = (resp_f && !resp_err_q && !resp_we_q) ? mem_rdata : 32'h0;

    l_rvalid = resp_l;
    l_err    = resp_l && resp_err_q;
    l_rdata  = (resp_l && !resp_err_q && !resp_we_q) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed scenarios followed by randomized
// traffic on both ports, checked by a grant predictor plus a response
// scoreboard against a behavioural memory model. Honors IMEM_ARB_RR_EN.
module tb_imem_arbiter;

  localparam int unsigned MEMORY_SIZE = 1024;
  localparam int unsigned WORDS       = MEMORY_SIZE / 4;
  localparam int unsigned AW          = 8;

  logic          clk;
  logic          reset;
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;
  logic          l_req;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          l_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  imem_arbiter #(.MEMORY_SIZE(MEMORY_SIZE)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous single-port memory seen by the DUT
  logic [31:0] mem_arr [WORDS];
  initial begin
    for (int i = 0; i < int'(WORDS); i++) mem_arr[i] = 32'h0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) mem_arr[mem_addr] <= mem_wdata;
        else        mem_rdata <= mem_arr[mem_addr];
      end
    end
  end

  // Reference state: word contents, expected responses, last granted port
  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t       f_q[$];
  resp_t       l_q[$];
  logic [31:0] ref_mem [int unsigned];
  bit          last_was_l = 1'b1;
  bit          log_en = 1'b0;
  byte         gnt_log[$];

  // Predictor: expected grant and memory strobes, pushes expected responses
  always @(negedge clk) begin : pred
    bit          ef, el, bad, wr;
    logic [31:0] a;
    resp_t       r;
    if (reset) begin
      ef = 1'b0; el = 1'b0;
    end else if (f_req && l_req) begin
`ifdef IMEM_ARB_RR_EN
      ef = last_was_l;
`else
      ef = 1'b0;
`endif
      el = !ef;
    end else begin
      ef = f_req; el = l_req;
    end
    chk("f_gnt", 32'(f_gnt), 32'(ef));
    chk("l_gnt", 32'(l_gnt), 32'(el));
    if (ef || el) begin
      a   = ef ? f_addr : l_addr;
      bad = (a % 4 != 0) || (a >= MEMORY_SIZE);
      wr  = el && l_we;
      chk("mem_en", 32'(mem_en), 32'(!bad));
      chk("mem_we", 32'(mem_we), 32'(wr && !bad));
      chk("mem_addr", 32'(mem_addr), (a / 4) % WORDS);
      if (wr && !bad) chk("mem_wdata", mem_wdata, l_wdata);
      r.due = cyc + 1;
      r.err = bad;
      if (bad || wr)                   r.data = 32'h0;
      else if (ref_mem.exists(a / 4))  r.data = ref_mem[a / 4];
      else                             r.data = 32'h0;
      if (wr && !bad) ref_mem[a / 4] = l_wdata;
      if (ef) f_q.push_back(r); else l_q.push_back(r);
      last_was_l = el;
    end else begin
      chk("mem_en_idle", 32'(mem_en), 32'h0);
      chk("mem_we_idle", 32'(mem_we), 32'h0);
      if (reset) begin
        chk("mem_addr_rst", 32'(mem_addr), 32'h0);
        chk("mem_wdata_rst", mem_wdata, 32'h0);
      end
    end
    if (reset) last_was_l = 1'b1;
    if (log_en) gnt_log.push_back(f_gnt ? 8'h46 : (l_gnt ? 8'h4C : 8'h2D));
  end

  // Monitor: pops the scoreboard whenever a response is presented
  always @(negedge clk) begin : mon
    resp_t r;
    chk("rvalid_exclusive", 32'(f_rvalid && l_rvalid), 32'h0);
    if (reset) begin
      chk("f_rvalid_rst", 32'(f_rvalid), 32'h0);
      chk("l_rvalid_rst", 32'(l_rvalid), 32'h0);
      chk("f_rdata_rst", f_rdata | l_rdata, 32'h0);
      chk("err_rst", 32'(f_err | l_err), 32'h0);
      f_q.delete();
      l_q.delete();
    end else begin
      if (f_rvalid) begin
        if (f_q.size() == 0) chk("f_rvalid_unexpected", 32'(f_rvalid), 32'h0);
        else begin
          r = f_q.pop_front();
          chk("f_latency", cyc, r.due);
          chk("f_rdata", f_rdata, r.data);
          chk("f_err", 32'(f_err), 32'(r.err));
        end
      end else begin
        chk("f_idle_zero", f_rdata | 32'(f_err), 32'h0);
        if (f_q.size() != 0 && f_q[0].due <= cyc) begin
          chk("f_rvalid_missing", 32'(f_rvalid), 32'h1);
          void'(f_q.pop_front());
        end
      end
      if (l_rvalid) begin
        if (l_q.size() == 0) chk("l_rvalid_unexpected", 32'(l_rvalid), 32'h0);
        else begin
          r = l_q.pop_front();
          chk("l_latency", cyc, r.due);
          chk("l_rdata", l_rdata, r.data);
          chk("l_err", 32'(l_err), 32'(r.err));
        end
      end else begin
        chk("l_idle_zero", l_rdata | 32'(l_err), 32'h0);
        if (l_q.size() != 0 && l_q[0].due <= cyc) begin
          chk("l_rvalid_missing", 32'(l_rvalid), 32'h1);
          void'(l_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1 with a request raised; returns at posedge+1 after grant
  task automatic wait_grant(input bit is_l);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (is_l ? l_gnt : f_gnt) break;
      t++;
      if (t > 60) begin
        chk(is_l ? "l_grant_timeout" : "f_grant_timeout",
            32'(is_l ? l_gnt : f_gnt), 32'h1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    f_req  = 1'b1;
    f_addr = a;
    wait_grant(1'b0);
    f_req  = 1'b0;
  endtask

  task automatic do_load(input logic we, input logic [31:0] a, input logic [31:0] d);
    l_req   = 1'b1;
    l_we    = we;
    l_addr  = a;
    l_wdata = d;
    wait_grant(1'b1);
    l_req   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
      1:       return 32'(MEMORY_SIZE + $urandom_range(0, 4000) * 4);
      2:       return 32'hFFFF_FFFC;
      default: return 32'($urandom_range(0, 63) * 4);
    endcase
  endfunction

  // Bounded run time
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    byte exp_pat [4];
    reset   = 1'b1;
    f_req   = 1'b1;
    f_addr  = 32'h8;
    l_req   = 1'b1;
    l_we    = 1'b1;
    l_addr  = 32'h10;
    l_wdata = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    f_req = 1'b0;
    l_req = 1'b0;
    idle(1);

    // Load, fetch back, write response, read via loader
    do_load(1'b1, 32'h8, 32'hDEAD_BEEF);
    do_fetch(32'h8);
    do_load(1'b1, 32'h10, 32'h1234_5678);
    do_fetch(32'h10);
    do_load(1'b0, 32'h10, 32'h0);
    idle(1);

    // Error requests, back to back
    do_fetch(32'h6);
    do_fetch(32'h400);
    do_load(1'b1, 32'h400, 32'hFFFF_FFFF);
    do_load(1'b0, 32'h3, 32'h0);
    do_fetch(32'h8);
    idle(2);

    // Tie for four cycles straight after reset
    reset = 1'b1;
    idle(1);
    reset   = 1'b0;
    f_req   = 1'b1; f_addr = 32'h8;
    l_req   = 1'b1; l_we = 1'b0; l_addr = 32'h10;
    log_en  = 1'b1;
    idle(4);
    log_en  = 1'b0;
    f_req   = 1'b0;
    l_req   = 1'b0;
`ifdef IMEM_ARB_RR_EN
    exp_pat = '{8'h46, 8'h4C, 8'h46, 8'h4C};
`else
    exp_pat = '{8'h4C, 8'h4C, 8'h4C, 8'h4C};
`endif
    chk("tie_log_len", 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_log.size()) chk($sformatf("tie_grant_%0d", i), 32'(gnt_log[i]), 32'(exp_pat[i]));
    end
    idle(2);

    // Reset lands in the response cycle of a fetch
    do_fetch(32'h8);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_drop_f_rvalid", 32'(f_rvalid), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_f_rvalid", 32'(f_rvalid), 32'h0);
    @(posedge clk);
    #1;

    // Randomized concurrent traffic on both ports
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          idle($urandom_range(0, 3));
          do_fetch(rand_addr());
        end
      end
      begin
        for (int j = 0; j < 150; j++) begin
          idle($urandom_range(0, 3));
          do_load(1'($urandom_range(0, 1)), rand_addr(), $urandom());
        end
      end
    join
    idle(4);
    chk("f_q_drained", 32'(f_q.size()), 32'h0);
    chk("l_q_drained", 32'(l_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter MEMORY_SIZE, default 1024, memory size in bytes; word depth is MEMORY_SIZE/4.
REQ-002 Parameter AW, default $clog2(MEMORY_SIZE/4), memory word-address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 f_req  in  1  fetch read request; held with f_addr until f_gnt.
REQ-006 f_addr  in  32  fetch byte address.
REQ-007 f_gnt  out  1  fetch request accepted this cycle.
REQ-008 f_rvalid  out  1  fetch response valid.
REQ-009 f_rdata  out  32  fetch read data.
REQ-010 f_err  out  1  fetch response is an error.
REQ-011 l_req  in  1  loader request; held with l_we, l_addr and l_wdata until l_gnt.
REQ-012 l_we  in  1  loader write (1) or read (0).
REQ-013 l_addr  in  32  loader byte address.
REQ-014 l_wdata  in  32  loader write data.
REQ-015 l_gnt, l_rvalid, l_err  out  1 each  loader grant, response valid and error.
REQ-016 l_rdata  out  32  loader read data.
REQ-017 mem_en, mem_we  out  1 each  memory enable and write enable.
REQ-018 mem_addr  out  AW  memory word address; mem_wdata out 32.
REQ-019 mem_rdata  in  32  memory data, valid one cycle after mem_en with mem_we=0.

Function
REQ-020 At most one request shall be granted per cycle; grant and mem_en shall be combinational in the request cycle.
REQ-021 mem_addr shall be addr[AW+1:2] of the granted requester; mem_we shall be l_we on a loader grant and 0 on a fetch grant.
REQ-022 A request is in error if addr[1:0]!=0 or addr>=MEMORY_SIZE; an error request shall be granted with mem_en=0.
REQ-023 Response FSM states: IDLE, F_RESP, L_RESP; a grant moves to F_RESP or L_RESP, and no grant moves to IDLE.
REQ-024 In F_RESP/L_RESP the owner's rvalid shall be 1 for exactly that cycle, with rdata=mem_rdata (reads), 0 (writes), or 0 with err=1 (error requests).
REQ-025 A new grant shall be allowed in F_RESP/L_RESP, giving one request per cycle, back to back.
REQ-026 Read latency from grant to rvalid shall be exactly 1 cycle.
REQ-027 rdata and err of the non-owner shall be 0; rvalid shall never be 1 on both ports at once.
REQ-028 If both requesters ask in the same cycle, arbitration follows REQ-033/REQ-034.

Reset
REQ-029 During reset, all outputs shall be 0 and the FSM shall be in IDLE.
REQ-030 No grant shall occur in a reset cycle.
REQ-031 A response pending when reset asserts shall be dropped: no rvalid in the cycle after reset.
REQ-032 The round-robin pointer shall reset to "loader last", so fetch wins the first tie.

Configuration
REQ-033 With IMEM_ARB_RR_EN defined, a tie shall grant the requester not granted most recently; the pointer updates on every grant.
REQ-034 Without IMEM_ARB_RR_EN, the loader shall always win a tie, no pointer register shall exist, and REQ-032 does not apply.

Verification
REQ-035 Reset, then f_req at 0x8 with mem word2=0xDEADBEEF -> f_gnt same cycle, mem_addr=2; next cycle f_rvalid=1, f_rdata=0xDEADBEEF, f_err=0.
REQ-036 Loader write 0x12345678 to 0x10, then fetch 0x10 -> mem_we=1 with mem_addr=4; l_rvalid=1 with l_rdata=0; fetch then returns 0x12345678.
REQ-037 f_addr=0x6 (misaligned), then f_addr=0x400 (MEMORY_SIZE=1024) -> each granted with mem_en=0; next cycle f_rvalid=1, f_err=1, f_rdata=0.
REQ-038 f_req and l_req held high for 4 cycles -> with IMEM_ARB_RR_EN: grants F,L,F,L; without: L,L,L,L and f_gnt=0.
REQ-039 Reset asserted in the cycle after a fetch grant -> f_rvalid stays 0 in that cycle and the next; FSM is IDLE.
